// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the pipelined MIPS core: control bundle layout,
// ALUOp encodings and small control-decoding helpers.
package mips_pipe_pkg;

  localparam int unsigned CTRL_W = 8;

  localparam int unsigned CTRL_REGWRITE = 7;
  localparam int unsigned CTRL_MEMTOREG = 6;
  localparam int unsigned CTRL_MEMREAD  = 5;
  localparam int unsigned CTRL_MEMWRITE = 4;
  localparam int unsigned CTRL_ALUSRC   = 3;
  localparam int unsigned CTRL_REGDST   = 2;
  localparam int unsigned CTRL_ALUOP_HI = 1;
  localparam int unsigned CTRL_ALUOP_LO = 0;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_RSVD  = 2'b11
  } aluop_e;

  // True when the bundle describes a load (its result arrives a stage late).
  function automatic logic ctrl_is_load(input logic [CTRL_W-1:0] ctrl);
    return ctrl[CTRL_MEMREAD];
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector: EX holds a load whose destination
// (rt) is read by the instruction currently in ID.
module load_use_detect
  import mips_pipe_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic              ex_valid,
  input  logic [CTRL_W-1:0] ex_ctrl,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  output logic              stall_c
);

  // id_rt is compared for every format, so I-types stall conservatively.
  always_comb begin
    stall_c = 1'b0;
    if (ex_valid && ctrl_is_load(ex_ctrl) && (ex_rt != '0) && id_valid &&
        ((ex_rt == id_rs) || (ex_rt == id_rt))) begin
      stall_c = 1'b1;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with write-back bypass of the register-file read
// ports, load-use stall generation and bubble insertion/counting.
module id_ex_stage
  import mips_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_ReadData1,
  input  logic [DATA_W-1:0] id_ReadData2,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [DATA_W-1:0] id_Imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              wb_RegWrite,
  input  logic [REG_AW-1:0] wb_WriteReg,
  input  logic [DATA_W-1:0] wb_WriteData,
  input  logic              flush,
  output logic              stall_out,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_ReadData1,
  output logic [DATA_W-1:0] ex_ReadData2,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic [DATA_W-1:0] ex_Imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CNT_W-1:0]  bubble_count
);

  logic              ex_valid_q, ex_valid_d;
  logic [DATA_W-1:0] ex_rd1_q, ex_rd1_d;
  logic [DATA_W-1:0] ex_rd2_q, ex_rd2_d;
  logic [REG_AW-1:0] ex_rs_q, ex_rs_d;
  logic [REG_AW-1:0] ex_rt_q, ex_rt_d;
  logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
  logic [DATA_W-1:0] ex_imm_q, ex_imm_d;
  logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
  logic [CNT_W-1:0]  bubble_count_q, bubble_count_d;

  logic              stall_c;
  logic              fwd1_c, fwd2_c;
  logic [DATA_W-1:0] op1_c, op2_c;

  load_use_detect #(
    .REG_AW (REG_AW)
  ) u_load_use_detect (
    .ex_valid (ex_valid_q),
    .ex_ctrl  (ex_ctrl_q),
    .ex_rt    (ex_rt_q),
    .id_valid (id_valid),
    .id_rs    (id_rs),
    .id_rt    (id_rt),
    .stall_c  (stall_c)
  );

  // RegisterFile writes on the same edge, so its same-cycle read is stale.
  always_comb begin
    fwd1_c = wb_RegWrite && (wb_WriteReg != '0) && (wb_WriteReg == id_rs);
    fwd2_c = wb_RegWrite && (wb_WriteReg != '0) && (wb_WriteReg == id_rt);
    op1_c  = fwd1_c ? wb_WriteData : id_ReadData1;
    op2_c  = fwd2_c ? wb_WriteData : id_ReadData2;
  end

  // Priority flush > stall > capture; flush and stall both leave a bubble.
  always_comb begin
    ex_valid_d     = 1'b0;
    ex_rd1_d       = '0;
    ex_rd2_d       = '0;
    ex_rs_d        = '0;
    ex_rt_d        = '0;
    ex_rd_d        = '0;
    ex_imm_d       = '0;
    ex_ctrl_d      = '0;
    bubble_count_d = bubble_count_q;
    if (flush) begin
      bubble_count_d = bubble_count_q;
    end else if (stall_c) begin
      if (bubble_count_q != '1) begin
        bubble_count_d = bubble_count_q + CNT_W'(1);
      end
    end else begin
      ex_valid_d = id_valid;
      ex_rd1_d   = op1_c;
      ex_rd2_d   = op2_c;
      ex_rs_d    = id_rs;
      ex_rt_d    = id_rt;
      ex_rd_d    = id_rd;
      ex_imm_d   = id_Imm;
      ex_ctrl_d  = id_valid ? id_ctrl : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q     <= 1'b0;
      ex_rd1_q       <= '0;
      ex_rd2_q       <= '0;
      ex_rs_q        <= '0;
      ex_rt_q        <= '0;
      ex_rd_q        <= '0;
      ex_imm_q       <= '0;
      ex_ctrl_q      <= '0;
      bubble_count_q <= '0;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_rd1_q       <= ex_rd1_d;
      ex_rd2_q       <= ex_rd2_d;
      ex_rs_q        <= ex_rs_d;
      ex_rt_q        <= ex_rt_d;
      ex_rd_q        <= ex_rd_d;
      ex_imm_q       <= ex_imm_d;
      ex_ctrl_q      <= ex_ctrl_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign stall_out    = stall_c;
  assign ex_valid     = ex_valid_q;
  assign ex_ReadData1 = ex_rd1_q;
  assign ex_ReadData2 = ex_rd2_q;
  assign ex_rs        = ex_rs_q;
  assign ex_rt        = ex_rt_q;
  assign ex_rd        = ex_rd_q;
  assign ex_Imm       = ex_imm_q;
  assign ex_ctrl      = ex_ctrl_q;
  assign bubble_count = bubble_count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a register-file/pipeline model predicts
// each cycle's stall and EX contents; a monitor pops and compares.
module tb_id_ex_stage;
  import mips_pipe_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, id_valid, wb_RegWrite, flush;
  logic [31:0] id_ReadData1, id_ReadData2, id_Imm, wb_WriteData;
  logic [4:0]  id_rs, id_rt, id_rd, wb_WriteReg;
  logic [7:0]  id_ctrl;

  logic        stall_out, ex_valid;
  logic [31:0] ex_ReadData1, ex_ReadData2, ex_Imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [7:0]  ex_ctrl;
  logic [15:0] bubble_count;

  logic        s_stall_out, s_ex_valid;
  logic [31:0] s_ex_ReadData1, s_ex_ReadData2, s_ex_Imm;
  logic [4:0]  s_ex_rs, s_ex_rt, s_ex_rd;
  logic [7:0]  s_ex_ctrl;
  logic [1:0]  s_bubble_count;

  id_ex_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_ReadData1(id_ReadData1), .id_ReadData2(id_ReadData2),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_Imm(id_Imm),
    .id_ctrl(id_ctrl), .wb_RegWrite(wb_RegWrite), .wb_WriteReg(wb_WriteReg),
    .wb_WriteData(wb_WriteData), .flush(flush), .stall_out(stall_out),
    .ex_valid(ex_valid), .ex_ReadData1(ex_ReadData1),
    .ex_ReadData2(ex_ReadData2), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_rd(ex_rd), .ex_Imm(ex_Imm), .ex_ctrl(ex_ctrl),
    .bubble_count(bubble_count)
  );

  // Narrow-counter copy so saturation is reachable in a short run.
  id_ex_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_ReadData1(id_ReadData1), .id_ReadData2(id_ReadData2),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_Imm(id_Imm),
    .id_ctrl(id_ctrl), .wb_RegWrite(wb_RegWrite), .wb_WriteReg(wb_WriteReg),
    .wb_WriteData(wb_WriteData), .flush(flush), .stall_out(s_stall_out),
    .ex_valid(s_ex_valid), .ex_ReadData1(s_ex_ReadData1),
    .ex_ReadData2(s_ex_ReadData2), .ex_rs(s_ex_rs), .ex_rt(s_ex_rt),
    .ex_rd(s_ex_rd), .ex_Imm(s_ex_Imm), .ex_ctrl(s_ex_ctrl),
    .bubble_count(s_bubble_count)
  );

  typedef struct packed {
    logic        stall;
    logic        valid;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [7:0]  ctrl;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        m;
  logic [31:0] rf [32];
  logic        last_stall;
  int          errors = 0;
  int          checks = 0;
  int          hazards_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one ID cycle and push the model's prediction for it.
  task automatic cycle(input logic r, input logic f, input logic v,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [31:0] imm, input logic [7:0] ctrl,
                       input logic wbw, input logic [4:0] wbr, input logic [31:0] wbd);
    logic [31:0] after [32];
    logic        st;
    @(negedge clk);
    rst = r; flush = f; id_valid = v;
    id_rs = rs; id_rt = rt; id_rd = rd; id_Imm = imm; id_ctrl = ctrl;
    id_ReadData1 = rf[rs]; id_ReadData2 = rf[rt];
    wb_RegWrite = wbw; wb_WriteReg = wbr; wb_WriteData = wbd;
    after = rf;
    if (wbw && wbr != 5'd0) after[wbr] = wbd;
    st = m.valid && m.ctrl[CTRL_MEMREAD] && (m.rt != 5'd0) && v &&
         ((m.rt == rs) || (m.rt == rt));
    if (st) hazards_seen++;
    if (r) begin
      m = '0;
    end else if (f) begin
      m = '{stall: 1'b0, valid: 1'b0, rd1: 32'd0, rd2: 32'd0, rs: 5'd0, rt: 5'd0,
            rd: 5'd0, imm: 32'd0, ctrl: 8'd0, cnt: m.cnt};
    end else if (st) begin
      m = '{stall: 1'b0, valid: 1'b0, rd1: 32'd0, rd2: 32'd0, rs: 5'd0, rt: 5'd0,
            rd: 5'd0, imm: 32'd0, ctrl: 8'd0, cnt: m.cnt + 32'd1};
    end else begin
      // Operands are the architectural register values once WB has committed.
      m.valid = v; m.rd1 = after[rs]; m.rd2 = after[rt];
      m.rs = rs; m.rt = rt; m.rd = rd; m.imm = imm;
      m.ctrl = v ? ctrl : 8'd0;
    end
    rf = after;
    m.stall = st;
    last_stall = st && !r && !f;
    sb_q.push_back(m);
  endtask

  initial begin : monitor
    exp_t e;
    logic [31:0] c16, c2;
    forever begin
      @(negedge clk);
      #4;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("stall_out", 64'(stall_out), 64'(e.stall));
        @(posedge clk);
        #1;
        c16 = (e.cnt > 32'd65535) ? 32'd65535 : e.cnt;
        c2  = (e.cnt > 32'd3) ? 32'd3 : e.cnt;
        check("ex_valid", 64'(ex_valid), 64'(e.valid));
        check("ex_ReadData1", 64'(ex_ReadData1), 64'(e.rd1));
        check("ex_ReadData2", 64'(ex_ReadData2), 64'(e.rd2));
        check("ex_rs", 64'(ex_rs), 64'(e.rs));
        check("ex_rt", 64'(ex_rt), 64'(e.rt));
        check("ex_rd", 64'(ex_rd), 64'(e.rd));
        check("ex_Imm", 64'(ex_Imm), 64'(e.imm));
        check("ex_ctrl", 64'(ex_ctrl), 64'(e.ctrl));
        check("bubble_count", 64'(bubble_count), 64'(c16));
        check("bubble_count_sat", 64'(s_bubble_count), 64'(c2));
      end
    end
  end

  initial begin : driver
    logic       r, f, v, wbw;
    logic [4:0] rs, rt, rd, wbr;
    logic [7:0] ctrl;
    logic [31:0] imm;
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    m = '0;
    last_stall = 1'b0;
    rst = 1'b1; flush = 1'b0; id_valid = 1'b1;
    id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd3; id_Imm = 32'hDEAD_BEEF;
    id_ctrl = 8'hFF; id_ReadData1 = 32'h1111_1111; id_ReadData2 = 32'h2222_2222;
    wb_RegWrite = 1'b0; wb_WriteReg = 5'd0; wb_WriteData = 32'd0;
    @(posedge clk);
    // Second reset cycle with busy ID inputs.
    cycle(1, 0, 1, 5'd7, 5'd8, 5'd9, 32'hFFFF_0001, 8'hFF, 1, 5'd4, 32'h5555);
    // Plain capture of an operand held in the register file.
    cycle(0, 0, 0, 5'd0, 5'd0, 5'd0, 32'd0, 8'h00, 1, 5'd1, 32'h0000_ABCD);
    cycle(0, 0, 1, 5'd1, 5'd0, 5'd4, 32'd12, 8'h80, 0, 5'd0, 32'd0);
    // Same-cycle WB bypass, then register 0 must not bypass.
    cycle(0, 0, 1, 5'd2, 5'd0, 5'd4, 32'd0, 8'h00, 1, 5'd2, 32'h0000_1234);
    cycle(0, 0, 1, 5'd0, 5'd0, 5'd4, 32'd0, 8'h00, 1, 5'd0, 32'h0000_1234);
    // id_valid low clears control.
    cycle(0, 0, 0, 5'd1, 5'd2, 5'd3, 32'd5, 8'hE7, 0, 5'd0, 32'd0);
    // Load-use: stall, bubble, then the held instruction captures.
    cycle(0, 0, 1, 5'd5, 5'd3, 5'd0, 32'd4, 8'hE0, 0, 5'd0, 32'd0);
    cycle(0, 0, 1, 5'd3, 5'd6, 5'd7, 32'd0, 8'h86, 0, 5'd0, 32'd0);
    cycle(0, 0, 1, 5'd3, 5'd6, 5'd7, 32'd0, 8'h86, 0, 5'd0, 32'd0);
    // Flush during a hazard: no count.
    cycle(0, 0, 1, 5'd5, 5'd3, 5'd0, 32'd4, 8'hE0, 0, 5'd0, 32'd0);
    cycle(0, 1, 1, 5'd3, 5'd6, 5'd7, 32'd0, 8'h86, 0, 5'd0, 32'd0);
    cycle(0, 0, 1, 5'd3, 5'd6, 5'd7, 32'd0, 8'h86, 0, 5'd0, 32'd0);
    // Reset during a hazard.
    cycle(0, 0, 1, 5'd5, 5'd3, 5'd0, 32'd4, 8'hE0, 0, 5'd0, 32'd0);
    cycle(1, 0, 1, 5'd6, 5'd3, 5'd7, 32'd0, 8'h86, 0, 5'd0, 32'd0);
    cycle(0, 0, 1, 5'd6, 5'd3, 5'd7, 32'd0, 8'h86, 0, 5'd0, 32'd0);
    // Repeated hazards drive the narrow counter into saturation.
    for (int k = 0; k < 6; k++) begin
      cycle(0, 0, 1, 5'd1, 5'd2, 5'd0, 32'd0, 8'hE0, 0, 5'd0, 32'd0);
      cycle(0, 0, 1, 5'd2, 5'd9, 5'd3, 32'd0, 8'h86, 0, 5'd0, 32'd0);
    end
    // Random traffic; a stalled ID instruction is re-presented.
    rs = 5'd0; rt = 5'd0; rd = 5'd0; imm = 32'd0; ctrl = 8'd0; v = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 99) < 2);
      f = ($urandom_range(0, 99) < 10);
      if (!last_stall) begin
        v    = ($urandom_range(0, 9) != 0);
        rs   = 5'($urandom_range(0, 3));
        rt   = 5'($urandom_range(0, 3));
        rd   = 5'($urandom_range(0, 31));
        imm  = $urandom;
        ctrl = 8'($urandom);
        ctrl[CTRL_MEMREAD] = ($urandom_range(0, 1) == 1);
      end
      wbw = ($urandom_range(0, 1) == 1);
      wbr = 5'($urandom_range(0, 3));
      cycle(r, f, v, rs, rt, rd, imm, ctrl, wbw, wbr, $urandom);
    end
    cycle(0, 0, 0, 5'd0, 5'd0, 5'd0, 32'd0, 8'd0, 0, 5'd0, 32'd0);
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    checks++;
    if (hazards_seen < 20) begin
      errors++;
      $display("FAIL hazard_coverage: got %0d expected at least 20", hazards_seen);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
